uart_frame_streamer: RTL and testbench

- Downstream of the UART frame receiver. Consumes one complete packed image frame of IMG_H x IMG_W 8-bit pixels, presented as a single wide vector with a finish flag.
- Captures the frame into a local shadow register and pulses the read-acknowledge back to the receiver, so the receiver can start collecting the next frame immediately.
- Replays the captured frame as a raster-order pixel stream with valid/ready handshake and row/col tags for the first LeNet-5 convolution stage.

---
 rtl/uart_frame_streamer.sv | 76 +++++++
 tb/tb_uart_frame_streamer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer: captures a packed IMG_H x IMG_W frame into a shadow register, acks it, and replays it as a raster pixel stream.
//   clk, rst (async, active-high)
//   frame_data/frame_finish -> frame_ack : frame handoff from the UART receiver
//   pix_data/pix_valid/pix_ready/pix_row/pix_col/pix_last : raster stream with row/col tags
//   busy : high while capturing or streaming
//   FRAME_BITREV_EN : when defined, each output byte is bit-reversed
module uart_frame_streamer #(
  parameter int IMG_W = 42,
  parameter int IMG_H = 42,
  parameter int PIX_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IMG_W*IMG_H*PIX_W-1:0]   frame_data,
  input  logic                           frame_finish,
  output logic                           frame_ack,
  output logic [PIX_W-1:0]               pix_data,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [5:0]                     pix_row,
  output logic [5:0]                     pix_col,
  output logic                           pix_last,
  output logic                           busy
);
  localparam int FRAME_W = IMG_W*IMG_H*PIX_W;
  localparam logic [5:0] ROW_MAX = 6'(IMG_H-1);
  localparam logic [5:0] COL_MAX = 6'(IMG_W-1);
  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;
  state_t state, state_nxt;
  logic [FRAME_W-1:0] shadow;
  logic [5:0] row, col;
  logic [PIX_W-1:0] head, pix;
  logic xfer, at_end;
  assign head   = shadow[FRAME_W-1 -: PIX_W];
  assign at_end = row == ROW_MAX && col == COL_MAX;
  assign xfer   = pix_valid && pix_ready;
`ifdef FRAME_BITREV_EN
  // serial packing puts the first received bit at byte bit 7, so flip it back
  for (genvar i = 0; i < PIX_W; i++) begin : g_rev
    assign pix[i] = head[PIX_W-1-i];
  end
`else
  assign pix = head;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE    ? (frame_finish ? CAPTURE : IDLE) :
                state == CAPTURE ? STREAM :
                state == STREAM  ? (xfer && at_end ? IDLE : STREAM) : IDLE;
  always_comb begin
    frame_ack = state == CAPTURE;
    pix_valid = state == STREAM;
    busy      = state != IDLE;
    pix_last  = at_end && pix_valid;
    pix_data  = pix_valid ? pix : '0;
    pix_row   = row;
    pix_col   = col;
  end
  // the head byte of the shadow is always the current pixel; shifting retires it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shadow <= '0;
      row    <= '0;
      col    <= '0;
    end else if (state == CAPTURE) begin
      shadow <= frame_data;
      row    <= '0;
      col    <= '0;
    end else if (xfer) begin
      shadow <= {shadow[FRAME_W-PIX_W-1:0], {PIX_W{1'b0}}};
      col    <= col == COL_MAX ? '0 : col + 6'd1;
      row    <= at_end ? '0 : col == COL_MAX ? row + 6'd1 : row;
    end
endmodule

// File: tb/tb_uart_frame_streamer.sv
// tb_uart_frame_streamer: randomized scoreboard bench for uart_frame_streamer.
module tb_uart_frame_streamer;
  localparam int W = 42, H = 42, NPIX = W*H, FW = NPIX*8;
  typedef struct {logic [7:0] d; int r; int c; bit l;} pix_t;
  logic clk = 0, rst = 1, frame_finish = 0, pix_ready = 1;
  logic [FW-1:0] frame_data = '0;
  logic frame_ack, pix_valid, pix_last, busy;
  logic [7:0] pix_data;
  logic [5:0] pix_row, pix_col;
  int asserts = 0, errs = 0, pops = 0, acks = 0, cyc = 0, ack_cyc = 0, last_cyc = 0;
  bit rand_ready = 0;
  pix_t sb[$];
  logic [7:0] img [NPIX];

  uart_frame_streamer dut (.clk(clk), .rst(rst), .frame_data(frame_data), .frame_finish(frame_finish),
    .frame_ack(frame_ack), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1 pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    asserts++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] xf(input logic [7:0] b);
`ifdef FRAME_BITREV_EN
    for (int i = 0; i < 8; i++) xf[i] = b[7-i];
`else
    xf = b;
`endif
  endfunction

  bit stall = 0, after_last = 0, prev_ack = 0;
  logic [7:0] p_d;
  logic [5:0] p_r, p_c;
  logic p_l;
  always @(negedge clk) begin
    pix_t e;
    if (frame_ack) begin
      chk("ack_pulse_width", prev_ack, 0);
      acks++;
      ack_cyc = cyc;
    end
    prev_ack = frame_ack;
    if (rst) begin
      stall = 0;
      after_last = 0;
    end else begin
      if (after_last) begin
        chk("idle_after_last", {busy, pix_valid}, 0);
        after_last = 0;
      end
      if (stall) chk("stall_hold", {pix_valid, pix_data, pix_row, pix_col, pix_last}, {1'b1, p_d, p_r, p_c, p_l});
      if (pix_valid && pix_ready) begin
        if (sb.size() == 0) chk("unexpected_pixel", 1, 0);
        else begin
          e = sb.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("pix_row", pix_row, e.r);
          chk("pix_col", pix_col, e.c);
          chk("pix_last", pix_last, e.l);
        end
        pops++;
        if (pix_last) begin
          last_cyc = cyc;
          after_last = 1;
        end
      end
      stall = pix_valid && !pix_ready;
      {p_d, p_r, p_c, p_l} = {pix_data, pix_row, pix_col, pix_last};
    end
  end

  task automatic fill(input int mode);
    for (int k = 0; k < NPIX; k++) img[k] = mode == 0 ? 8'(k) : 8'($urandom);
    if (mode == 2) img[0] = 8'h01;
  endtask

  task automatic send_frame(input bit chk_lat);
    int n = 0;
    bit got = 0;
    @(posedge clk); #1;
    for (int k = 0; k < NPIX; k++) begin
      frame_data[FW-1-8*k -: 8] = img[k];
      sb.push_back('{xf(img[k]), k / W, k % W, k == NPIX-1});
    end
    frame_finish = 1;
    repeat (5000) begin
      @(negedge clk);
      n++;
      if (frame_ack) begin got = 1; break; end
    end
    chk("ack_seen", got, 1);
    if (chk_lat) chk("ack_latency", n, 2);
    @(posedge clk); #1 frame_finish = 0;
  endtask

  task automatic drain(input int base, input int n);
    repeat (20000) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("transfer_count", pops - base, n);
  endtask

  initial begin
    int base, a0;
    bit hit;
    repeat (2) @(negedge clk);
    chk("rst_out", {frame_ack, pix_valid, pix_data, pix_row, pix_col, pix_last, busy}, 0);
    @(posedge clk); #3 rst = 0;
    @(negedge clk);
    chk("idle_out", {frame_ack, pix_valid, busy}, 0);
    // frame A: k mod 256, full rate
    fill(0); base = pops;
    send_frame(1);
    drain(base, NPIX);
    // frame B: random data under backpressure
    rand_ready = 1;
    fill(1); base = pops;
    send_frame(1);
    drain(base, NPIX);
    // frames C and D back to back, D's finish raised mid-stream
    fill(1); base = pops;
    send_frame(1);
    repeat (300) @(posedge clk);
    fill(1);
    send_frame(0);
    chk("b2b_ack_gap", ack_cyc - last_cyc, 2);
    drain(base, 2*NPIX);
    // frame E: async reset at pixel 500
    rand_ready = 0;
    fill(1);
    send_frame(1);
    base = pops - 1;
    hit = 0;
    repeat (3000) begin
      @(posedge clk); #3;
      if (pops - base >= 500) begin hit = 1; break; end
    end
    chk("reached_px500", hit, 1);
    chk("px500_index", pops - base, 500);
    a0 = acks;
    rst = 1;
    #1;
    chk("rst_mid_out", {pix_valid, pix_last, busy, frame_ack}, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 0;
    repeat (10) @(negedge clk);
    chk("no_extra_ack", acks, a0);
    chk("idle_after_rst", {busy, pix_valid}, 0);
    // frame F: first byte 0x01, backpressure
    rand_ready = 1;
    fill(2); base = pops;
    send_frame(1);
    drain(base, NPIX);
    chk("total_acks", acks, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errs);
    $finish;
  end
endmodule
